// File: rtl/scr1_tb_test_monitor.sv
// Test-completion monitor: watches per-hart committed PCs for the exit
// address, captures each hart's a0 result, and reports pass/fail/timeout
// per test while keeping saturating pass/total counters across a test list.
module scr1_tb_test_monitor #(
  parameter int               N_HARTS        = 1,
  parameter int               XLEN           = 32,
  parameter logic [XLEN-1:0]  EXIT_ADDR      = 32'h000000F8,
  parameter int               TIMEOUT_CYCLES = 1000000,
  parameter int               CNT_W          = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      test_start,
  input  logic [N_HARTS-1:0]        pc_vld,
  input  logic [N_HARTS*XLEN-1:0]   pc,
  input  logic [N_HARTS*XLEN-1:0]   a0,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [N_HARTS-1:0]        hart_done,
  output logic [N_HARTS-1:0]        hart_fail,
  output logic [31:0]               cycle_cnt,
  output logic [CNT_W-1:0]          tests_total,
  output logic [CNT_W-1:0]          tests_passed
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  // A zero limit disables the watchdog; the compare value is then never used.
  localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [N_HARTS-1:0]   r_hart_done;
  logic [N_HARTS-1:0]   r_hart_fail;
  logic [31:0]          r_cycle_cnt;
  logic                 r_to_flag;
  logic                 r_done;
  logic                 r_pass;
  logic                 r_timeout;
  logic [CNT_W-1:0]     r_tests_total;
  logic [CNT_W-1:0]     r_tests_passed;

  logic [N_HARTS-1:0]   w_hit;
  logic [N_HARTS-1:0]   w_done_nxt;
  logic [N_HARTS-1:0]   w_fail_nxt;
  logic                 w_to_hit;
  logic                 w_pass_rpt;

  function automatic logic [31:0] sat_inc_cyc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // First exit hit per hart; the pc_vld term short-circuits so an X on an
  // invalid lane cannot reach the compare result.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_HARTS; i++) begin
      w_hit[i] = pc_vld[i] && (pc[i*XLEN +: XLEN] == EXIT_ADDR) && !r_hart_done[i];
    end
  end

  // Next-state logic; completion is judged on the post-update done vector so
  // the last hart counts in its own cycle and wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = r_hart_done;
    w_fail_nxt  = r_hart_fail;
    w_to_hit    = 1'b0;
    for (int i = 0; i < N_HARTS; i++) begin
      if (w_hit[i]) begin
        w_done_nxt[i] = 1'b1;
        w_fail_nxt[i] = (a0[i*XLEN +: XLEN] != '0);
      end
    end
    case (r_state)
      ST_IDLE: begin
        if (test_start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!test_start) begin
          if (&w_done_nxt) begin
            w_state_nxt = ST_REPORT;
          end else if (TO_EN && (r_cycle_cnt == TO_LAST)) begin
            w_state_nxt = ST_REPORT;
            w_to_hit    = 1'b1;
          end
        end
      end
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_pass_rpt = (&r_hart_done) && !(|r_hart_fail) && !r_to_flag;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Per-test tracking: cleared on start or restart, updated only while running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hart_done <= '0;
      r_hart_fail <= '0;
      r_cycle_cnt <= '0;
      r_to_flag   <= 1'b0;
    end else if (((r_state == ST_IDLE) || (r_state == ST_RUN)) && test_start) begin
      r_hart_done <= '0;
      r_hart_fail <= '0;
      r_cycle_cnt <= '0;
      r_to_flag   <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_hart_done <= w_done_nxt;
      r_hart_fail <= w_fail_nxt;
      r_cycle_cnt <= sat_inc_cyc(r_cycle_cnt);
      r_to_flag   <= w_to_hit;
    end
  end

  // Result and cross-test counters, committed during the single REPORT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_timeout      <= 1'b0;
      r_tests_total  <= '0;
      r_tests_passed <= '0;
    end else begin
      r_done <= (r_state == ST_REPORT);
      if (r_state == ST_REPORT) begin
        r_pass        <= w_pass_rpt;
        r_timeout     <= r_to_flag;
        r_tests_total <= sat_inc_cnt(r_tests_total);
        if (w_pass_rpt) r_tests_passed <= sat_inc_cnt(r_tests_passed);
      end
    end
  end

  assign busy         = (r_state == ST_RUN);
  assign done         = r_done;
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign hart_done    = r_hart_done;
  assign hart_fail    = r_hart_fail;
  assign cycle_cnt    = r_cycle_cnt;
  assign tests_total  = r_tests_total;
  assign tests_passed = r_tests_passed;

endmodule

// File: tb/tb_scr1_tb_test_monitor.sv
// Bench for scr1_tb_test_monitor: two harts, 100-cycle watchdog, 2-bit
// counters. Each scenario queues its expected report; the monitor block pops
// and compares when done pulses.
module tb_scr1_tb_test_monitor;

  localparam int          NH   = 2;
  localparam int          XL   = 32;
  localparam int          TO   = 100;
  localparam int          CW   = 2;
  localparam logic [31:0] EXIT = 32'h000000F8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             test_start = 1'b0;
  logic [NH-1:0]    pc_vld = '0;
  logic [NH*XL-1:0] pc = {EXIT, EXIT};
  logic [NH*XL-1:0] a0 = '0;
  logic             busy, done, pass, timeout;
  logic [NH-1:0]    hart_done, hart_fail;
  logic [31:0]      cycle_cnt;
  logic [CW-1:0]    tests_total, tests_passed;

  int checks = 0;
  int errors = 0;
  int m_total = 0;
  int m_passed = 0;

  typedef struct { int k; int h; logic [31:0] v; } ev_t;
  typedef struct {
    logic        p;
    logic        t;
    logic [1:0]  hd;
    logic [1:0]  hf;
    logic [31:0] cnt;
    logic [1:0]  tot;
    logic [1:0]  psd;
  } exp_t;

  ev_t  ev_q[$];
  exp_t exp_q[$];
  exp_t me;
  logic done_q = 1'b0;

  scr1_tb_test_monitor #(
    .N_HARTS(NH), .XLEN(XL), .EXIT_ADDR(EXIT), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .test_start(test_start), .pc_vld(pc_vld),
    .pc(pc), .a0(a0), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .hart_done(hart_done), .hart_fail(hart_fail), .cycle_cnt(cycle_cnt),
    .tests_total(tests_total), .tests_passed(tests_passed)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic logic [1:0] sat3(input int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_ev(input int k, input int h, input logic [31:0] v);
    ev_t e;
    e.k = k; e.h = h; e.v = v;
    ev_q.push_back(e);
  endtask

  task automatic expect_report(input logic p, input logic t, input logic [1:0] hd,
                               input logic [1:0] hf, input logic [31:0] c);
    exp_t e;
    m_total++;
    if (p) m_passed++;
    e.p = p; e.t = t; e.hd = hd; e.hf = hf; e.cnt = c;
    e.tot = sat3(m_total); e.psd = sat3(m_passed);
    exp_q.push_back(e);
  endtask

  task automatic start_test();
    test_start = 1'b1;
    cyc(1);
    test_start = 1'b0;
  endtask

  // Drive RUN edges kfrom..kto (edge 1 is the first edge after the start edge).
  // pc always carries the exit address; only pc_vld selects real retirements.
  task automatic drive_run(input int kfrom, input int kto);
    for (int k = kfrom; k <= kto; k++) begin
      pc_vld = '0;
      a0 = '0;
      foreach (ev_q[j]) begin
        if (ev_q[j].k == k) begin
          pc_vld[ev_q[j].h] = 1'b1;
          a0[ev_q[j].h*XL +: XL] = ev_q[j].v;
        end
      end
      cyc(1);
    end
    pc_vld = '0;
    a0 = '0;
  endtask

  task automatic clear_ev();
    ev_q.delete();
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 300) begin
      cyc(1);
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done got no done within %0d cycles", lat);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (done_q !== 1'b0) begin errors++; $display("FAIL done_width got two-cycle done"); end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done exp none");
      end else begin
        me = exp_q.pop_front();
        checks++; if (pass !== me.p) begin errors++; $display("FAIL rpt_pass got %0b exp %0b", pass, me.p); end
        checks++; if (timeout !== me.t) begin errors++; $display("FAIL rpt_timeout got %0b exp %0b", timeout, me.t); end
        checks++; if (hart_done !== me.hd) begin errors++; $display("FAIL rpt_hart_done got %0b exp %0b", hart_done, me.hd); end
        checks++; if (hart_fail !== me.hf) begin errors++; $display("FAIL rpt_hart_fail got %0b exp %0b", hart_fail, me.hf); end
        checks++; if (cycle_cnt !== me.cnt) begin errors++; $display("FAIL rpt_cycle_cnt got %0d exp %0d", cycle_cnt, me.cnt); end
        checks++; if (tests_total !== me.tot) begin errors++; $display("FAIL rpt_tests_total got %0d exp %0d", tests_total, me.tot); end
        checks++; if (tests_passed !== me.psd) begin errors++; $display("FAIL rpt_tests_passed got %0d exp %0d", tests_passed, me.psd); end
      end
    end
    done_q = done;
  end

  task automatic check_all_zero(input string tag);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy got %0b exp 0", tag, busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done got %0b exp 0", tag, done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL %s_pass got %0b exp 0", tag, pass); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout got %0b exp 0", tag, timeout); end
    checks++; if (hart_done !== 2'b00) begin errors++; $display("FAIL %s_hart_done got %0b exp 0", tag, hart_done); end
    checks++; if (hart_fail !== 2'b00) begin errors++; $display("FAIL %s_hart_fail got %0b exp 0", tag, hart_fail); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL %s_cycle_cnt got %0d exp 0", tag, cycle_cnt); end
    checks++; if (tests_total !== 2'd0) begin errors++; $display("FAIL %s_tests_total got %0d exp 0", tag, tests_total); end
    checks++; if (tests_passed !== 2'd0) begin errors++; $display("FAIL %s_tests_passed got %0d exp 0", tag, tests_passed); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_pass();
    int lat;
    clear_ev();
    start_test();
    add_ev(51, 0, 32'd0);
    add_ev(51, 1, 32'd0);
    drive_run(1, 25);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy got %0b exp 1", busy); end
    checks++; if (cycle_cnt !== 32'd25) begin errors++; $display("FAIL pass_midcnt got %0d exp 25", cycle_cnt); end
    checks++; if (hart_done !== 2'b00) begin errors++; $display("FAIL pass_vld_gate got %0b exp 0", hart_done); end
    expect_report(1'b1, 1'b0, 2'b11, 2'b00, 32'd51);
    drive_run(26, 51);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy_report got %0b exp 0", busy); end
    wait_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL pass_latency got %0d exp 1", lat); end
  endtask

  task automatic test_fail();
    clear_ev();
    start_test();
    add_ev(5, 0, 32'd3);
    add_ev(7, 1, 32'd0);
    expect_report(1'b0, 1'b0, 2'b11, 2'b01, 32'd7);
    drive_run(1, 7);
    // test_start lands on the REPORT cycle and must be dropped.
    test_start = 1'b1;
    cyc(1);
    test_start = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL fail_done got %0b exp 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL report_start_busy got %0b exp 0", busy); end
    cyc(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL report_start_idle got %0b exp 0", busy); end
  endtask

  task automatic test_two_harts();
    int lat;
    clear_ev();
    start_test();
    add_ev(10, 0, 32'd0);
    add_ev(20, 0, 32'd5);
    add_ev(30, 1, 32'd0);
    expect_report(1'b1, 1'b0, 2'b11, 2'b00, 32'd30);
    drive_run(1, 29);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL two_busy got %0b exp 1", busy); end
    checks++; if (hart_done !== 2'b01) begin errors++; $display("FAIL two_hart_done got %0b exp 01", hart_done); end
    checks++; if (hart_fail !== 2'b00) begin errors++; $display("FAIL two_first_wins got %0b exp 00", hart_fail); end
    drive_run(30, 30);
    wait_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL two_latency got %0d exp 1", lat); end
  endtask

  task automatic test_timeout();
    int lat;
    clear_ev();
    start_test();
    add_ev(5, 0, 32'd0);
    expect_report(1'b0, 1'b1, 2'b01, 2'b00, 32'd100);
    drive_run(1, 99);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy99 got %0b exp 1", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_held got %0b exp 0", timeout); end
    drive_run(100, 100);
    wait_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL to_latency got %0d exp 1", lat); end
    cyc(3);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_hold got %0b exp 1", timeout); end
  endtask

  task automatic test_simul();
    int lat;
    clear_ev();
    start_test();
    add_ev(40, 0, 32'd0);
    add_ev(100, 1, 32'd0);
    expect_report(1'b1, 1'b0, 2'b11, 2'b00, 32'd100);
    drive_run(1, 100);
    wait_done(lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL simul_latency got %0d exp 1", lat); end
  endtask

  task automatic test_restart();
    int lat;
    clear_ev();
    start_test();
    add_ev(5, 0, 32'd7);
    drive_run(1, 9);
    checks++; if (hart_done !== 2'b01) begin errors++; $display("FAIL rs_pre_done got %0b exp 01", hart_done); end
    checks++; if (cycle_cnt !== 32'd9) begin errors++; $display("FAIL rs_pre_cnt got %0d exp 9", cycle_cnt); end
    clear_ev();
    start_test();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rs_busy got %0b exp 1", busy); end
    checks++; if (hart_done !== 2'b00) begin errors++; $display("FAIL rs_hart_done got %0b exp 0", hart_done); end
    checks++; if (hart_fail !== 2'b00) begin errors++; $display("FAIL rs_hart_fail got %0b exp 0", hart_fail); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL rs_cnt got %0d exp 0", cycle_cnt); end
    checks++; if (tests_total !== sat3(m_total)) begin errors++; $display("FAIL rs_total got %0d exp %0d", tests_total, sat3(m_total)); end
    checks++; if (tests_passed !== sat3(m_passed)) begin errors++; $display("FAIL rs_passed got %0d exp %0d", tests_passed, sat3(m_passed)); end
    add_ev(3, 0, 32'd0);
    add_ev(4, 1, 32'd0);
    expect_report(1'b1, 1'b0, 2'b11, 2'b00, 32'd4);
    drive_run(1, 4);
    wait_done(lat);
  endtask

  task automatic test_midrst();
    clear_ev();
    cyc(1);
    start_test();
    drive_run(1, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    m_total = 0;
    m_passed = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_saturate();
    int lat;
    int kl;
    for (int i = 0; i < 5; i++) begin
      clear_ev();
      start_test();
      kl = (2 + i > 3) ? 2 + i : 3;
      add_ev(2 + i, 0, 32'd0);
      add_ev(3, 1, 32'd0);
      expect_report(1'b1, 1'b0, 2'b11, 2'b00, kl);
      drive_run(1, kl);
      wait_done(lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL sat_latency got %0d exp 1", lat); end
      cyc(1);
    end
    checks++; if (tests_total !== sat3(m_total)) begin errors++; $display("FAIL sat_total got %0d exp %0d", tests_total, sat3(m_total)); end
    checks++; if (tests_passed !== sat3(m_passed)) begin errors++; $display("FAIL sat_passed got %0d exp %0d", tests_passed, sat3(m_passed)); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_two_harts();
    test_timeout();
    test_simul();
    test_restart();
    test_midrst();
    test_saturate();
    cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reports got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
